instr_fetch_buffer: RTL and testbench



---
 rtl/instr_fetch_buffer_pkg.sv | 14 +
 rtl/instr_fetch_buffer.sv | 114 +++++++++++
 tb/tb_instr_fetch_buffer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_buffer_pkg.sv
// Shared defaults and slot layout for the instruction fetch buffer.
package instr_fetch_buffer_pkg;

    localparam int unsigned DEPTH_DEFAULT    = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
        logic        filled;
    } slot_t;

endpackage

// File: rtl/instr_fetch_buffer.sv
// In-order instruction fetch buffer: issues fetches, collects in-order responses,
// presents the oldest filled slot to decode and discards responses made stale by redirects.
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic [31:0] inst_rdata_i,
    input  logic        inst_data_ok_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_stall_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        id_adel_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    slot_t         slots_q [DEPTH];
    logic [PW-1:0] alloc_ptr_q, fill_ptr_q, head_ptr_q;
    logic [CW-1:0] count_q, pend_q, drop_cnt_q;
    logic [CW-1:0] drop_sum;
    logic [31:0]   fetch_pc_q;
    logic          halt_q;

    logic  has_free, aligned, fetch_ok, req_accept, adel_alloc, fill, drop, pop;
    slot_t head;

    always_comb begin
        has_free   = count_q < CW'(DEPTH);
        aligned    = fetch_pc_q[1:0] == 2'b00;
        // resetn gates the request so nothing is issued while reset is held.
        fetch_ok   = resetn & has_free & ~halt_q & ~redirect_i;
        inst_req_o = fetch_ok & aligned;
        req_accept = inst_req_o & inst_addr_ok_i;
        adel_alloc = fetch_ok & ~aligned;
        drop       = inst_data_ok_i & (drop_cnt_q != '0);
        fill       = inst_data_ok_i & (drop_cnt_q == '0) & (pend_q != '0);
        head       = slots_q[head_ptr_q];
        id_valid_o = (count_q != '0) & head.filled;
        id_instr_o = id_valid_o ? head.instr : 32'h0;
        id_pc_o    = id_valid_o ? head.pc : 32'h0;
        id_adel_o  = id_valid_o & head.adel;
        pop        = id_valid_o & ~id_stall_i;
        // Responses still owed to freed slots plus those already owed, less one arriving now.
        drop_sum   = pend_q + drop_cnt_q;
        if (inst_data_ok_i && drop_sum != '0) begin
            drop_sum = drop_sum - CW'(1);
        end
    end

    assign inst_addr_o = fetch_pc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots_q[i] <= '0;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
            pend_q      <= '0;
            drop_cnt_q  <= '0;
            fetch_pc_q  <= RESET_PC;
            halt_q      <= 1'b0;
        end else if (redirect_i) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
            pend_q      <= '0;
            drop_cnt_q  <= drop_sum;
            fetch_pc_q  <= redirect_pc_i;
            halt_q      <= 1'b0;
        end else begin
            if (req_accept) begin
                slots_q[alloc_ptr_q] <= slot_t'{pc: fetch_pc_q, instr: 32'h0, adel: 1'b0,
                                                filled: 1'b0};
                alloc_ptr_q          <= alloc_ptr_q + PW'(1);
                fetch_pc_q           <= fetch_pc_q + 32'd4;
            end
            if (adel_alloc) begin
                slots_q[alloc_ptr_q] <= slot_t'{pc: fetch_pc_q, instr: 32'h0, adel: 1'b1,
                                                filled: 1'b1};
                alloc_ptr_q          <= alloc_ptr_q + PW'(1);
                halt_q               <= 1'b1;
            end
            if (fill) begin
                slots_q[fill_ptr_q].instr  <= inst_rdata_i;
                slots_q[fill_ptr_q].filled <= 1'b1;
                fill_ptr_q                 <= fill_ptr_q + PW'(1);
            end
            if (drop) begin
                drop_cnt_q <= drop_cnt_q - CW'(1);
            end
            if (pop) begin
                head_ptr_q <= head_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(req_accept | adel_alloc) - CW'(pop);
            pend_q  <= pend_q + CW'(req_accept) - CW'(fill);
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with an in-order memory model and a pc scoreboard.
module tb_instr_fetch_buffer;
    import instr_fetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic [31:0] inst_rdata_i;
    logic        inst_data_ok_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_stall_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_adel_o;

    always #5 clk = ~clk;

    instr_fetch_buffer dut (
        .clk           (clk),
        .resetn        (resetn),
        .inst_req_o    (inst_req_o),
        .inst_addr_o   (inst_addr_o),
        .inst_addr_ok_i(inst_addr_ok_i),
        .inst_rdata_i  (inst_rdata_i),
        .inst_data_ok_i(inst_data_ok_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_stall_i    (id_stall_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_adel_o     (id_adel_o)
    );

    int          errors = 0;
    int          checks = 0;
    int          n_accept = 0;
    logic [31:0] mem_q[$];
    logic [31:0] sb_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_pc;
    logic [31:0] redir_pc;
    bit          mem_ready, data_en, stall, do_redirect;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0f0f_3c3c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
        checks++;
        assert (pop_log.size() > idx) else begin
            errors++;
            $error("FAIL %s: observed %0d pops, expected pc %h at pop %0d", tag,
                   pop_log.size(), exp, idx);
        end
        if (pop_log.size() > idx) chk(tag, pop_log[idx], exp);
    endtask

    // One clock cycle: drive after the falling edge, then sample and update the models.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        inst_addr_ok_i = mem_ready;
        if (data_en && mem_q.size() > 0) begin
            inst_data_ok_i = 1'b1;
            inst_rdata_i   = instr_of(mem_q[0]);
        end else begin
            inst_data_ok_i = 1'b0;
            inst_rdata_i   = 32'h0;
        end
        redirect_i    = do_redirect;
        redirect_pc_i = redir_pc;
        id_stall_i    = stall;
        #1;
        if (inst_data_ok_i) void'(mem_q.pop_front());
        if (!id_valid_o) begin
            chk("idle_instr", id_instr_o, 32'h0);
            chk("idle_pc", id_pc_o, 32'h0);
        end
        if (id_valid_o && !id_stall_i && !redirect_i) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL pop_underflow: observed pc=%h expected no valid output", id_pc_o);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pop_pc", id_pc_o, e);
                chk("pop_instr", id_instr_o, instr_of(e));
                chk("pop_adel", 32'(id_adel_o), 32'h0);
                pop_log.push_back(id_pc_o);
            end
        end
        if (inst_req_o && inst_addr_ok_i) begin
            chk("fetch_addr", inst_addr_o, exp_pc);
            mem_q.push_back(exp_pc);
            sb_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_accept++;
        end
        if (redirect_i) begin
            sb_q.delete();
            exp_pc = redir_pc;
        end
        do_redirect = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", 32'(inst_req_o), 32'h0);
        chk("rst_addr", inst_addr_o, RESET_PC_DEFAULT);
        chk("rst_valid", 32'(id_valid_o), 32'h0);
        chk("rst_instr", id_instr_o, 32'h0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_adel", 32'(id_adel_o), 32'h0);
    endtask

    initial begin
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = 32'h0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        id_stall_i     = 1'b0;
        redir_pc       = 32'h0;
        exp_pc         = RESET_PC_DEFAULT;
        resetn         = 1'b1;
        #1 resetn      = 1'b0;

        // Reset state
        repeat (3) step();
        chk_reset_outputs();
        #2 resetn = 1'b1;

        // Streaming fetch, data one cycle after accept
        mem_ready = 1'b1;
        data_en   = 1'b1;
        step();
        chk("req_after_reset", 32'(inst_req_o), 32'h1);
        repeat (6) step();
        chk_log("stream_pc0", 0, 32'hbfc0_0000);
        chk_log("stream_pc1", 1, 32'hbfc0_0004);
        chk_log("stream_pc2", 2, 32'hbfc0_0008);
        mem_ready = 1'b0;
        repeat (8) step();
        chk("drained_valid", 32'(id_valid_o), 32'h0);

        // Stall with memory always ready: buffer fills to DEPTH and holds its head
        stall     = 1'b1;
        mem_ready = 1'b1;
        n_accept  = 0;
        repeat (10) step();
        chk("stall_accepts", 32'(n_accept), 32'd4);
        chk("stall_full_req", 32'(inst_req_o), 32'h0);
        chk("stall_valid", 32'(id_valid_o), 32'h1);
        if (sb_q.size() > 0) begin
            chk("stall_head_pc", id_pc_o, sb_q[0]);
            chk("stall_head_instr", id_instr_o, instr_of(sb_q[0]));
        end
        stall     = 1'b0;
        mem_ready = 1'b0;
        repeat (8) step();

        // Redirect with two requests outstanding
        mem_ready = 1'b1;
        data_en   = 1'b0;
        repeat (2) step();
        mem_ready   = 1'b0;
        do_redirect = 1'b1;
        redir_pc    = 32'h8000_0100;
        pop_log.delete();
        step();
        mem_ready = 1'b1;
        data_en   = 1'b1;
        step();
        chk("drop_cnt_two", 32'(dut.drop_cnt_q), 32'd2);
        repeat (8) step();
        chk_log("redir_first_pc", 0, 32'h8000_0100);
        mem_ready = 1'b0;
        repeat (8) step();

        // Redirect coinciding with a response, three outstanding
        mem_ready = 1'b1;
        data_en   = 1'b0;
        repeat (3) step();
        data_en     = 1'b1;
        do_redirect = 1'b1;
        redir_pc    = 32'h8000_0200;
        pop_log.delete();
        step();
        step();
        chk("drop_cnt_coincide", 32'(dut.drop_cnt_q), 32'd2);
        repeat (8) step();
        chk_log("coincide_first_pc", 0, 32'h8000_0200);
        mem_ready = 1'b0;
        repeat (8) step();

        // Misaligned redirect: address-error slot, fetch halted until next redirect
        mem_ready   = 1'b1;
        stall       = 1'b1;
        do_redirect = 1'b1;
        redir_pc    = 32'h8000_0102;
        n_accept    = 0;
        step();
        repeat (4) step();
        chk("adel_no_req", 32'(inst_req_o), 32'h0);
        chk("adel_no_accept", 32'(n_accept), 32'h0);
        chk("adel_valid", 32'(id_valid_o), 32'h1);
        chk("adel_flag", 32'(id_adel_o), 32'h1);
        chk("adel_instr", id_instr_o, 32'h0);
        chk("adel_pc", id_pc_o, 32'h8000_0102);
        do_redirect = 1'b1;
        redir_pc    = 32'h8000_0300;
        pop_log.delete();
        step();
        stall = 1'b0;
        repeat (8) step();
        chk_log("resume_first_pc", 0, 32'h8000_0300);
        mem_ready = 1'b0;
        repeat (8) step();

        // Reset mid-operation with buffered and outstanding entries
        stall     = 1'b1;
        mem_ready = 1'b1;
        data_en   = 1'b1;
        repeat (3) step();
        data_en = 1'b0;
        step();
        chk("pre_reset_valid", 32'(id_valid_o), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk_reset_outputs();
        mem_q.delete();
        sb_q.delete();
        exp_pc    = RESET_PC_DEFAULT;
        mem_ready = 1'b0;
        stall     = 1'b0;
        repeat (2) step();
        #2 resetn = 1'b1;
        mem_ready = 1'b1;
        data_en   = 1'b1;
        pop_log.delete();
        step();
        chk("req_after_rereset", 32'(inst_req_o), 32'h1);
        repeat (6) step();
        chk_log("rereset_first_pc", 0, 32'hbfc0_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
